// File: rtl/esm_issue_queue.sv
// esm_issue_queue: age-ordered compacting issue buffer. Each cycle the oldest
// entry free of RAW/WAW/WAR hazards against older entries, and of busy source
// registers in the result-latency scoreboard, is issued.
module esm_issue_queue #(
   parameter int INSTR_W = 32,
   parameter int BS      = 16,
   parameter int LAT     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INSTR_W-1:0]      Instr_in,
   input  logic                    RegWrite,
   input  logic                    ALUSrc,
   output logic                    out_valid,
   output logic [INSTR_W-1:0]      Instr_out,
   output logic                    out_RegWrite,
   output logic [$clog2(BS+1)-1:0] count
);
   localparam int CW = $clog2(BS+1);
   localparam int IW = $clog2(BS);
   localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h0000_0013);
   localparam logic [2:0]         SB_LOAD = 3'(LAT - 1);

   logic [INSTR_W-1:0] instr_q [BS];
   logic               rw_q    [BS];
   logic               as_q    [BS];
   logic [2:0]         sb      [32];

   logic [4:0] rs1  [BS];
   logic [4:0] rs2  [BS];
   logic [4:0] rd   [BS];
   logic       s1_v [BS];
   logic       s2_v [BS];
   logic       d_v  [BS];
   logic       elig [BS];

   logic          hit;
   logic [IW-1:0] sel;
   logic          enq;
   logic [CW-1:0] wr_idx;

   // No fall-through: a full queue refuses input even in an issuing cycle.
   assign in_ready = (count < CW'(BS));
   assign enq      = in_valid & in_ready & ~flush;
   // A new entry lands behind the survivors of this cycle's shift.
   assign wr_idx   = hit ? count - CW'(1) : count;

   // Decode register fields; x0 and unused rs2 never count as operands.
   always_comb begin
      for (int k = 0; k < BS; k++) begin
         rd[k]   = instr_q[k][11:7];
         rs1[k]  = instr_q[k][19:15];
         rs2[k]  = instr_q[k][24:20];
         s1_v[k] = (k < int'(count)) && (rs1[k] != 5'd0);
         s2_v[k] = (k < int'(count)) && !as_q[k] && (rs2[k] != 5'd0);
         d_v[k]  = (k < int'(count)) && rw_q[k] && (rd[k] != 5'd0);
      end
   end

   // Hazard screen of every slot against the scoreboard and all older slots.
   always_comb begin
      for (int k = 0; k < BS; k++) begin
         elig[k] = (k < int'(count));
         if (s1_v[k] && (sb[rs1[k]] != 3'd0)) elig[k] = 1'b0;
         if (s2_v[k] && (sb[rs2[k]] != 3'd0)) elig[k] = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (d_v[j] && ((s1_v[k] && (rs1[k] == rd[j])) ||
                           (s2_v[k] && (rs2[k] == rd[j]))))
               elig[k] = 1'b0;
            if (d_v[k] && d_v[j] && (rd[k] == rd[j]))
               elig[k] = 1'b0;
            if (d_v[k] && ((s1_v[j] && (rs1[j] == rd[k])) ||
                           (s2_v[j] && (rs2[j] == rd[k]))))
               elig[k] = 1'b0;
         end
      end
   end

   // Pick the oldest eligible slot.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int k = BS - 1; k >= 0; k--) begin
         if (elig[k]) begin
            hit = 1'b1;
            sel = IW'(k);
         end
      end
   end

   // Occupancy, registered issue port and latency scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         out_valid    <= 1'b0;
         Instr_out    <= NOP;
         out_RegWrite <= 1'b0;
         for (int r = 0; r < 32; r++) sb[r] <= 3'd0;
      end else if (flush) begin
         count        <= '0;
         out_valid    <= 1'b0;
         Instr_out    <= NOP;
         out_RegWrite <= 1'b0;
         for (int r = 0; r < 32; r++) sb[r] <= 3'd0;
      end else begin
         count        <= count + CW'(enq) - CW'(hit);
         out_valid    <= hit;
         Instr_out    <= hit ? instr_q[sel] : NOP;
         out_RegWrite <= hit & rw_q[sel];
         for (int r = 0; r < 32; r++) begin
            if (sb[r] != 3'd0) sb[r] <= sb[r] - 3'd1;
         end
         if (hit && d_v[sel]) sb[rd[sel]] <= SB_LOAD;
      end
   end

   // Entry storage: compact over the issued slot, then append the new entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BS; i++) begin
         if (enq && (i == int'(wr_idx))) begin
            instr_q[i] <= Instr_in;
            rw_q[i]    <= RegWrite;
            as_q[i]    <= ALUSrc;
         end else if (hit && (i >= int'(sel)) && (i < BS - 1)) begin
            instr_q[i] <= instr_q[(i + 1) % BS];
            rw_q[i]    <= rw_q[(i + 1) % BS];
            as_q[i]    <= as_q[(i + 1) % BS];
         end
      end
   end

endmodule

// File: tb/tb_esm_issue_queue.sv
// Bench for esm_issue_queue: dut0 (BS=8, LAT=3) and dut1 (BS=4, LAT=8),
// directed scenarios plus randomized traffic against a time-stamp model.
module tb_esm_issue_queue;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_s    [2];
   logic        in_valid_s [2];
   logic        in_ready_s [2];
   logic [31:0] instr_s    [2];
   logic        rw_s       [2];
   logic        as_s       [2];
   logic        out_valid_s[2];
   logic [31:0] iout_s     [2];
   logic        out_rw_s   [2];
   logic [3:0]  count0;
   logic [2:0]  count1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   esm_issue_queue #(.INSTR_W(32), .BS(8), .LAT(3)) dut0 (
      .clk(clk), .rst(rst), .flush(flush_s[0]), .in_valid(in_valid_s[0]),
      .in_ready(in_ready_s[0]), .Instr_in(instr_s[0]), .RegWrite(rw_s[0]),
      .ALUSrc(as_s[0]), .out_valid(out_valid_s[0]), .Instr_out(iout_s[0]),
      .out_RegWrite(out_rw_s[0]), .count(count0));

   esm_issue_queue #(.INSTR_W(32), .BS(4), .LAT(8)) dut1 (
      .clk(clk), .rst(rst), .flush(flush_s[1]), .in_valid(in_valid_s[1]),
      .in_ready(in_ready_s[1]), .Instr_in(instr_s[1]), .RegWrite(rw_s[1]),
      .ALUSrc(as_s[1]), .out_valid(out_valid_s[1]), .Instr_out(iout_s[1]),
      .out_RegWrite(out_rw_s[1]), .count(count1));

   // Reference model: entries in age order, per-register earliest-issue edge.
   typedef struct {
      logic [31:0] instr;
      logic        rw;
      logic        imm;
   } ent_t;

   ent_t mq[$];
   int   ready_at[32];
   int   tnow;

   function automatic int cnt(int d);
      return (d == 0) ? int'(count0) : int'(count1);
   endfunction

   function automatic int m_dst(ent_t e);
      return (e.rw && (e.instr[11:7] != 5'd0)) ? int'(e.instr[11:7]) : 0;
   endfunction

   function automatic bit m_src(ent_t e, int r);
      if (r == 0) return 1'b0;
      if (int'(e.instr[19:15]) == r) return 1'b1;
      return !e.imm && (int'(e.instr[24:20]) == r);
   endfunction

   function automatic bit m_elig(int k);
      ent_t e;
      int   dk;
      int   dj;
      e  = mq[k];
      dk = m_dst(e);
      for (int r = 1; r < 32; r++)
         if (m_src(e, r) && (tnow < ready_at[r])) return 1'b0;
      for (int j = 0; j < k; j++) begin
         dj = m_dst(mq[j]);
         if ((dj != 0) && m_src(e, dj)) return 1'b0;
         if ((dk != 0) && (dk == dj)) return 1'b0;
         if ((dk != 0) && m_src(mq[j], dk)) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge(input int bs, input int lat, input logic fl,
                             input logic iv, input logic [31:0] ins,
                             input logic rw, input logic imm,
                             output logic eov, output logic [31:0] eio,
                             output logic eorw);
      int   pick;
      bit   room;
      ent_t ne;
      eov  = 1'b0;
      eio  = NOP;
      eorw = 1'b0;
      if (fl) begin
         mq.delete();
         for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end else begin
         room = (mq.size() < bs);
         pick = -1;
         for (int k = 0; k < mq.size(); k++)
            if ((pick < 0) && m_elig(k)) pick = k;
         if (pick >= 0) begin
            eov  = 1'b1;
            eio  = mq[pick].instr;
            eorw = mq[pick].rw;
            if (m_dst(mq[pick]) != 0) ready_at[m_dst(mq[pick])] = tnow + lat;
            mq.delete(pick);
         end
         if (iv && room) begin
            ne.instr = ins;
            ne.rw    = rw;
            ne.imm   = imm;
            mq.push_back(ne);
         end
      end
      tnow++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(int d, logic [31:0] ins, logic rw, logic imm);
      in_valid_s[d] = 1'b1;
      instr_s[d]    = ins;
      rw_s[d]       = rw;
      as_s[d]       = imm;
   endtask

   task automatic idle(int d);
      in_valid_s[d] = 1'b0;
      instr_s[d]    = '0;
      rw_s[d]       = 1'b0;
      as_s[d]       = 1'b0;
   endtask

   task automatic drain(int n);
      idle(0);
      idle(1);
      repeat (n) step();
   endtask

   task automatic test_reset();
      int n;
      checks++; if (out_valid_s[0] !== 1'b0) begin failures++; $display("FAIL por_ov got=%b want=0", out_valid_s[0]); end
      checks++; if (iout_s[0] !== NOP) begin failures++; $display("FAIL por_iout got=%h want=%h", iout_s[0], NOP); end
      checks++; if (in_ready_s[0] !== 1'b1) begin failures++; $display("FAIL por_ready got=%b want=1", in_ready_s[0]); end
      step(); step();
      rst = 1'b0;
      step();
      n = 0;
      while ((cnt(0) != 5) && (n < 20)) begin
         put(0, 32'h0010_8093, 1'b1, 1'b1);
         step();
         n++;
      end
      checks++; if (cnt(0) != 5) begin failures++; $display("FAIL rst_fill count=%0d want=5", cnt(0)); end
      idle(0);
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid_s[0] !== 1'b0) begin failures++; $display("FAIL rst_ov got=%b want=0", out_valid_s[0]); end
      checks++; if (iout_s[0] !== NOP) begin failures++; $display("FAIL rst_iout got=%h want=%h", iout_s[0], NOP); end
      checks++; if (out_rw_s[0] !== 1'b0) begin failures++; $display("FAIL rst_orw got=%b want=0", out_rw_s[0]); end
      checks++; if (cnt(0) != 0) begin failures++; $display("FAIL rst_count got=%0d want=0", cnt(0)); end
      checks++; if (in_ready_s[0] !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", in_ready_s[0]); end
      step();
      rst = 1'b0;
      put(0, 32'h00A0_0093, 1'b1, 1'b1);
      step();
      checks++; if (cnt(0) != 1) begin failures++; $display("FAIL post_rst_count got=%0d want=1", cnt(0)); end
      idle(0);
      step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h00A0_0093)) begin failures++; $display("FAIL post_rst_issue ov=%b iout=%h want 1/00a00093", out_valid_s[0], iout_s[0]); end
      drain(6);
   endtask

   task automatic test_raw_bypass();
      put(0, 32'h00A0_0093, 1'b1, 1'b1); step();
      put(0, 32'h0140_0113, 1'b1, 1'b1); step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h00A0_0093)) begin failures++; $display("FAIL raw_e ov=%b iout=%h want 1/00a00093", out_valid_s[0], iout_s[0]); end
      put(0, 32'h0020_81B3, 1'b1, 1'b0); step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h0140_0113)) begin failures++; $display("FAIL raw_e1 ov=%b iout=%h want 1/01400113", out_valid_s[0], iout_s[0]); end
      put(0, 32'h0040_04B7, 1'b1, 1'b1); step();
      checks++; if ((out_valid_s[0] !== 1'b0) || (iout_s[0] !== NOP)) begin failures++; $display("FAIL raw_e2 ov=%b iout=%h want 0/00000013", out_valid_s[0], iout_s[0]); end
      idle(0); step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h0040_04B7)) begin failures++; $display("FAIL bypass_e3 ov=%b iout=%h want 1/004004b7", out_valid_s[0], iout_s[0]); end
      step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h0020_81B3) || (out_rw_s[0] !== 1'b1)) begin failures++; $display("FAIL raw_e4 ov=%b iout=%h orw=%b want 1/002081b3/1", out_valid_s[0], iout_s[0], out_rw_s[0]); end
      step();
      checks++; if (cnt(0) != 0) begin failures++; $display("FAIL raw_empty count=%0d want=0", cnt(0)); end
      drain(6);
   endtask

   task automatic test_war_waw();
      put(0, 32'h00A0_0093, 1'b1, 1'b1); step();
      put(0, 32'h0020_81B3, 1'b1, 1'b0); step();
      checks++; if (iout_s[0] !== 32'h00A0_0093) begin failures++; $display("FAIL war_p1 iout=%h want=00a00093", iout_s[0]); end
      put(0, 32'h0050_0093, 1'b1, 1'b1); step();
      checks++; if (out_valid_s[0] !== 1'b0) begin failures++; $display("FAIL war_p2 ov=%b want=0", out_valid_s[0]); end
      idle(0); step();
      checks++; if ((out_valid_s[0] !== 1'b0) || (cnt(0) != 2)) begin failures++; $display("FAIL war_p3 ov=%b count=%0d want 0/2", out_valid_s[0], cnt(0)); end
      step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h0020_81B3)) begin failures++; $display("FAIL war_p4 ov=%b iout=%h want 1/002081b3", out_valid_s[0], iout_s[0]); end
      step();
      checks++; if ((out_valid_s[0] !== 1'b1) || (iout_s[0] !== 32'h0050_0093)) begin failures++; $display("FAIL war_p5 ov=%b iout=%h want 1/00500093", out_valid_s[0], iout_s[0]); end
      drain(6);
   endtask

   task automatic test_full();
      put(1, 32'h00A0_0093, 1'b1, 1'b1); step();
      put(1, 32'h0010_8113, 1'b1, 1'b1); step();
      checks++; if (iout_s[1] !== 32'h00A0_0093) begin failures++; $display("FAIL full_s1 iout=%h want=00a00093", iout_s[1]); end
      repeat (3) step();
      checks++; if ((cnt(1) != 4) || (in_ready_s[1] !== 1'b0)) begin failures++; $display("FAIL full_s4 count=%0d ready=%b want 4/0", cnt(1), in_ready_s[1]); end
      put(1, 32'h0010_8193, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if ((cnt(1) != 4) || (in_ready_s[1] !== 1'b0) || (out_valid_s[1] !== 1'b0)) begin failures++; $display("FAIL full_hold%0d count=%0d ready=%b ov=%b want 4/0/0", i, cnt(1), in_ready_s[1], out_valid_s[1]); end
      end
      step();
      checks++; if ((out_valid_s[1] !== 1'b1) || (iout_s[1] !== 32'h0010_8113) || (in_ready_s[1] !== 1'b1) || (cnt(1) != 3)) begin failures++; $display("FAIL full_s9 ov=%b iout=%h ready=%b count=%0d want 1/00108113/1/3", out_valid_s[1], iout_s[1], in_ready_s[1], cnt(1)); end
      step();
      checks++; if ((iout_s[1] !== 32'h0010_8113) || (cnt(1) != 3)) begin failures++; $display("FAIL full_s10 iout=%h count=%0d want 00108113/3", iout_s[1], cnt(1)); end
      idle(1);
      repeat (3) step();
      checks++; if ((iout_s[1] !== 32'h0010_8193) || (cnt(1) != 0)) begin failures++; $display("FAIL full_s13 iout=%h count=%0d want 00108193/0", iout_s[1], cnt(1)); end
      drain(10);
   endtask

   task automatic test_flush();
      put(1, 32'h0010_8093, 1'b1, 1'b1);
      repeat (4) step();
      checks++; if ((cnt(1) != 3) || (out_valid_s[1] !== 1'b0)) begin failures++; $display("FAIL flush_pre count=%0d ov=%b want 3/0", cnt(1), out_valid_s[1]); end
      put(1, 32'h0020_0113, 1'b1, 1'b1);
      flush_s[1] = 1'b1;
      step();
      flush_s[1] = 1'b0;
      checks++; if ((cnt(1) != 0) || (out_valid_s[1] !== 1'b0) || (iout_s[1] !== NOP) || (in_ready_s[1] !== 1'b1)) begin failures++; $display("FAIL flush_edge count=%0d ov=%b iout=%h ready=%b want 0/0/00000013/1", cnt(1), out_valid_s[1], iout_s[1], in_ready_s[1]); end
      put(1, 32'h0010_8113, 1'b1, 1'b1); step();
      checks++; if ((cnt(1) != 1) || (out_valid_s[1] !== 1'b0)) begin failures++; $display("FAIL flush_drop count=%0d ov=%b want 1/0", cnt(1), out_valid_s[1]); end
      idle(1); step();
      checks++; if ((out_valid_s[1] !== 1'b1) || (iout_s[1] !== 32'h0010_8113)) begin failures++; $display("FAIL flush_sb ov=%b iout=%h want 1/00108113", out_valid_s[1], iout_s[1]); end
      put(1, 32'h00A0_0093, 1'b1, 1'b1); step();
      idle(1); step();
      checks++; if ((out_valid_s[1] !== 1'b1) || (iout_s[1] !== 32'h00A0_0093)) begin failures++; $display("FAIL flush_next ov=%b iout=%h want 1/00a00093", out_valid_s[1], iout_s[1]); end
      drain(10);
   endtask

   task automatic test_random(int d, int bs, int lat);
      logic        fl, iv, rw, imm, eov, eorw, erdy;
      logic [31:0] ins, eio;
      idle(d);
      flush_s[d] = 1'b1;
      step();
      flush_s[d] = 1'b0;
      mq.delete();
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      tnow = 0;
      for (int c = 0; c < 400; c++) begin
         fl  = ($urandom_range(0, 59) == 0);
         iv  = ($urandom_range(0, 3) != 0);
         rw  = ($urandom_range(0, 4) != 0);
         imm = $urandom_range(0, 1) == 1;
         ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), 7'($urandom)};
         flush_s[d]    = fl;
         in_valid_s[d] = iv;
         instr_s[d]    = ins;
         rw_s[d]       = rw;
         as_s[d]       = imm;
         erdy = (mq.size() < bs);
         checks++; if (in_ready_s[d] !== erdy) begin failures++; $display("FAIL rnd%0d_ready c=%0d got=%b want=%b", d, c, in_ready_s[d], erdy); end
         model_edge(bs, lat, fl, iv, ins, rw, imm, eov, eio, eorw);
         step();
         checks++; if ((out_valid_s[d] !== eov) || (iout_s[d] !== eio) || (out_rw_s[d] !== eorw)) begin failures++; $display("FAIL rnd%0d_out c=%0d got=%b/%h/%b want=%b/%h/%b", d, c, out_valid_s[d], iout_s[d], out_rw_s[d], eov, eio, eorw); end
         checks++; if (cnt(d) != mq.size()) begin failures++; $display("FAIL rnd%0d_count c=%0d got=%0d want=%0d", d, c, cnt(d), mq.size()); end
      end
      flush_s[d] = 1'b0;
      drain(10);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         flush_s[d] = 1'b0;
         idle(d);
      end
      #1;
      test_reset();
      test_raw_bypass();
      test_war_waw();
      test_full();
      test_flush();
      test_random(0, 8, 3);
      test_random(1, 4, 8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
